add_serial: RTL and testbench

- Parametrised, digit-serial add/subtract unit; next generation of the 16-bit combinational ripple adder with overflow flag.
- Processes WIDTH-bit operands DIGIT bits per clock.
- Registered carry chains digits across cycles.
- Start/done handshake; reports unsigned carry-out and signed overflow separately.
- Sits between register-file operand latches and the result bus in area-constrained datapaths.

---
 rtl/add_serial.sv | 99 +++++++++
 tb/tb_add_serial.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial.sv
// Digit-serial add/subtract unit: WIDTH-bit operands, DIGIT bits per clock.
// Registered carry links digits; reports unsigned carry-out and signed overflow.
module add_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ov
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("add_serial: WIDTH must be a multiple of DIGIT, DIGIT >= 1");
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_d;
    logic [DIGIT-1:0] b_d;
    logic [DIGIT-1:0] r_d;
    logic             c_out;
    logic             c_msb;
    logic             last;
    logic             accept;

    always_comb begin
        a_d            = a_q[int'(cnt)*DIGIT +: DIGIT];
        b_d            = b_q[int'(cnt)*DIGIT +: DIGIT];
        {c_out, r_d}   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
        // carry into the digit's top bit recovered from its sum bit
        c_msb          = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ r_d[DIGIT-1];
        last           = (cnt == CW'(N - 1));
        accept         = start && (state == IDLE || state == DONE);
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sum[int'(cnt)*DIGIT +: DIGIT] <= r_d;
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        co    <= c_out;
                        ov    <= c_msb ^ c_out;
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                IDLE, DONE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: three parametrisations, directed
// vectors with hand-computed results plus a reference-model sweep.
module tb_add_serial;

    typedef struct {
        int          k;
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start [3];
    logic        sub   [3];
    logic [15:0] a     [3];
    logic [15:0] b     [3];
    wire  [2:0]  busy;
    wire  [2:0]  done;
    wire  [2:0]  co;
    wire  [2:0]  ov;
    wire  [15:0] sum0;
    wire  [7:0]  sum1;
    wire  [15:0] sum2;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    add_serial #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub[0]),
        .a(a[0]), .b(b[0]), .busy(busy[0]), .done(done[0]),
        .sum(sum0), .co(co[0]), .ov(ov[0])
    );

    add_serial #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub[1]),
        .a(a[1][7:0]), .b(b[1][7:0]), .busy(busy[1]), .done(done[1]),
        .sum(sum1), .co(co[1]), .ov(ov[1])
    );

    add_serial #(.WIDTH(16), .DIGIT(1)) u_w16d1 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub[2]),
        .a(a[2]), .b(b[2]), .busy(busy[2]), .done(done[2]),
        .sum(sum2), .co(co[2]), .ov(ov[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sum_of(int k);
        case (k)
            0:       return sum0;
            1:       return {8'h00, sum1};
            default: return sum2;
        endcase
    endfunction

    function automatic int n_of(int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Reference: whole-word arithmetic, overflow from operand/result signs
    function automatic exp_t model(int k, logic [15:0] x, logic [15:0] y,
                                   logic sb);
        exp_t        m;
        int          w;
        logic [15:0] mask;
        logic [15:0] yy;
        logic [16:0] f;
        logic        xs;
        logic        ys;
        logic        rs;
        w    = (k == 1) ? 8 : 16;
        mask = (k == 1) ? 16'h00FF : 16'hFFFF;
        yy   = (sb ? ~y : y) & mask;
        f    = {1'b0, x & mask} + {1'b0, yy} + {16'h0, sb};
        xs   = x[w-1];
        ys   = y[w-1];
        rs   = f[w-1];
        m.k  = k;
        m.s  = f[15:0] & mask;
        m.c  = f[w];
        m.v  = sb ? (xs != ys && rs != xs) : (xs == ys && rs != xs);
        return m;
    endfunction

    task automatic chk(string nm, int act, int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (done[k]) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", k, -1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("result_unit", k, e.k);
                        chk("sum", int'(sum_of(k)), int'(e.s));
                        chk("co", int'(co[k]), int'(e.c));
                        chk("ov", int'(ov[k]), int'(e.v));
                    end
                end
            end
        end
    end

    // Issue one operation at the current negedge and wait for its done
    task automatic op(int k, logic [15:0] x, logic [15:0] y, logic sb,
                      logic [15:0] es, logic ec, logic ev, bit lat);
        int t;
        int nb;
        a[k]     = x;
        b[k]     = y;
        sub[k]   = sb;
        start[k] = 1'b1;
        q.push_back('{k, es, ec, ev});
        @(negedge clk);
        start[k] = 1'b0;
        a[k]     = 16'($urandom);
        b[k]     = 16'($urandom);
        sub[k]   = ~sb;
        t  = 1;
        nb = 0;
        while (!done[k] && t < 40) begin
            if (busy[k]) nb++;
            @(negedge clk);
            t++;
        end
        chk("done_seen", int'(done[k]), 1);
        if (lat) begin
            chk("latency", t, n_of(k) + 1);
            chk("busy_cycles", nb, n_of(k));
        end
    endtask

    task automatic rnd_op(int k, logic sb, logic [15:0] x, logic [15:0] y);
        exp_t m;
        m = model(k, x, y, sb);
        op(k, x, y, sb, m.s, m.c, m.v, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            sub[k]   = 1'b0;
            a[k]     = '0;
            b[k]     = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", int'(busy[k]), 0);
            chk("rst_done", int'(done[k]), 0);
            chk("rst_sum", int'(sum_of(k)), 0);
            chk("rst_co_ov", int'({co[k], ov[k]}), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        op(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        op(0, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        op(0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
        op(0, 16'h5A5A, 16'h0000, 1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b1);

        // start during RUN is ignored; start held through DONE chains
        a[0] = 16'h0100; b[0] = 16'h0023; sub[0] = 1'b0; start[0] = 1'b1;
        q.push_back('{0, 16'h0123, 1'b0, 1'b0});
        @(negedge clk);
        a[0] = 16'h1234; b[0] = 16'h1111;
        @(negedge clk);
        start[0] = 1'b0; a[0] = 16'hDEAD; b[0] = 16'hBEEF;
        @(negedge clk);
        @(negedge clk);
        a[0] = 16'h1234; b[0] = 16'h1111; start[0] = 1'b1;
        q.push_back('{0, 16'h2345, 1'b0, 1'b0});
        @(negedge clk);
        chk("chain_done", int'(done[0]), 1);
        @(negedge clk);
        start[0] = 1'b0;
        chk("chain_no_idle", int'(busy[0]), 1);
        t = 0;
        while (!done[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("chain_done2", int'(done[0]), 1);

        // reset in the second RUN cycle aborts with no done pulse
        @(negedge clk);
        a[0] = 16'h1357; b[0] = 16'h2468; sub[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_done", int'(done[0]), 0);
        chk("abort_sum", int'(sum0), 0);
        chk("abort_co_ov", int'({co[0], ov[0]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_idle", int'(busy[0]), 0);

        op(1, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        op(1, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b1);
        op(1, 16'h0010, 16'h0020, 1'b1, 16'h00F0, 1'b0, 1'b0, 1'b1);
        op(2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        op(2, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            x = 16'($urandom);
            y = 16'($urandom);
            rnd_op(0, 1'b0, x, y);
            rnd_op(0, 1'b1, x, y);
            rnd_op(2, 1'b0, x, y);
            rnd_op(2, 1'b1, x, y);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
